data_bus_responder: RTL

Target side of the processor data-memory interface. Decodes each data access into an on-chip data RAM of `MEM_SIZE` words or a small memory-mapped I/O page. The I/O page holds an output port register, a free-running 36-bit cycle counter and a 4-deep transmit FIFO with a valid/ready drain port. Reads are combinational, so the single-cycle processor gets `data_out` in the same cycle it drives `data_addr`.

---
 rtl/data_bus_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_bus_responder.sv
// Data-side bus target: on-chip RAM plus an I/O page (OUT port, 36-bit cycle counter, 4-deep TX FIFO).
// Reads are purely combinational and side-effect free; all state changes on the rising clock edge.
module data_bus_responder #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 data_write_enable,
    input  logic [ADDR_SIZE-1:0] data_addr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic [WORD_SIZE-1:0] out_port,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    localparam int RAM_AW = $clog2(MEM_SIZE);

    logic [WORD_SIZE-1:0] ram [MEM_SIZE];
    logic [WORD_SIZE-1:0] out_reg;
    logic [35:0]          cnt;
    logic [WORD_SIZE-1:0] fifo_mem [4];
    logic [1:0]           rd_ptr;
    logic [1:0]           wr_ptr;
    logic [2:0]           count;
    logic                 ovf;

    logic       in_ram;
    logic       is_io;
    logic [3:0] io_off;
    logic       wr_out;
    logic       wr_cyc_lo;
    logic       push;
    logic       pop;
    logic       push_ok;
    logic       flush;
    logic       clr_ovf;
    logic       full;

    // The I/O page 0x3FFF0..0x3FFFF is the top 16 words of the address space.
    assign in_ram    = data_addr < ADDR_SIZE'(MEM_SIZE);
    assign is_io     = data_addr[ADDR_SIZE-1:4] == {(ADDR_SIZE-4){1'b1}};
    assign io_off    = data_addr[3:0];

    assign wr_out    = data_write_enable && is_io && io_off == 4'h0;
    assign wr_cyc_lo = data_write_enable && is_io && io_off == 4'h1;
    assign push      = data_write_enable && is_io && io_off == 4'h3;
    assign flush     = data_write_enable && is_io && io_off == 4'h4 && data_in[1];
    assign clr_ovf   = data_write_enable && is_io && io_off == 4'h4 && data_in[0];

    assign full      = count == 3'd4;
    assign tx_valid  = count != 3'd0;
    assign tx_data   = fifo_mem[rd_ptr];
    assign out_port  = out_reg;
    assign pop       = tx_valid && tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop) && !flush;

    always_comb begin
        data_out = '0;
        if (in_ram) begin
            data_out = ram[data_addr[RAM_AW-1:0]];
        end else if (is_io) begin
            case (io_off)
                4'h0:    data_out = out_reg;
                4'h1:    data_out = WORD_SIZE'(cnt[17:0]);
                4'h2:    data_out = WORD_SIZE'(cnt[35:18]);
                4'h3:    data_out = WORD_SIZE'({count, ovf, full, !tx_valid});
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (data_write_enable && in_ram) begin
            ram[data_addr[RAM_AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg <= '0;
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            if (wr_out) begin
                out_reg <= data_in;
            end
            cnt <= wr_cyc_lo ? 36'd0 : cnt + 36'd1;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 2'd1;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + 3'd1;
                    2'b01:   count <= count - 3'd1;
                    default: count <= count;
                endcase
            end

            if (clr_ovf) begin
                ovf <= 1'b0;
            end else if (push && full && !pop && !flush) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule
